// File: rtl/dma_rd_ctrl.sv
// Region reader: splits a word region into SDRAM read bursts and streams the returned words into the output buffer; DMA_RD_STALL_CNT_EN adds a stall_cnt port.
// Zero-latency p_rd -> ob pass-through; stalls on p_cmd_full, p_rd_empty or ob_full and never pops past the burst length.
module dma_rd_ctrl #(
    parameter int BURST_LEN = 16,
    parameter int ADDR_W    = 30
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              reads_en,
    input  logic [31:0]       start_addr,
    input  logic [15:0]       total_words,
    output logic              p_cmd_en,
    output logic [2:0]        p_cmd_instr,
    output logic [5:0]        p_cmd_bl,
    output logic [ADDR_W-1:0] p_cmd_byte_addr,
    input  logic              p_cmd_full,
    output logic              p_rd_en,
    input  logic [31:0]       p_rd_data,
    input  logic              p_rd_empty,
    output logic              ob_we,
    output logic [31:0]       ob_data,
    input  logic              ob_full,
    output logic              busy,
    output logic              done
`ifdef DMA_RD_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, ISSUE, XFER, DONE} state_t;

    localparam logic [15:0] BURST_W = 16'(BURST_LEN);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       remaining;
    logic [15:0]       remaining_after;
    logic [15:0]       len;
    logic [6:0]        cur_len;
    logic [6:0]        beat_cnt;
    logic              do_latch, do_issue, rd_pop, last_beat;

    assign len             = (remaining < BURST_W) ? remaining : BURST_W;
    assign remaining_after = remaining - {9'd0, cur_len};

    always_comb begin
        state_nxt = state;
        do_latch  = 1'b0;
        do_issue  = 1'b0;
        rd_pop    = 1'b0;
        last_beat = 1'b0;
        unique case (state)
            IDLE: begin
                if (reads_en) begin
                    do_latch  = 1'b1;
                    state_nxt = (total_words == 16'd0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (!reads_en) begin
                    state_nxt = IDLE;
                end else if (!p_cmd_full) begin
                    do_issue  = 1'b1;
                    state_nxt = XFER;
                end
            end
            XFER: begin
                rd_pop = !p_rd_empty && !ob_full;
                // A dropped reads_en only takes effect once the burst is fully drained.
                if (rd_pop && (beat_cnt + 7'd1 == cur_len)) begin
                    last_beat = 1'b1;
                    if (!reads_en)
                        state_nxt = IDLE;
                    else if (remaining_after != 16'd0)
                        state_nxt = ISSUE;
                    else
                        state_nxt = DONE;
                end
            end
            DONE: begin
                if (!reads_en)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            cur_len   <= '0;
            beat_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if (do_latch) begin
                addr      <= ADDR_W'(start_addr) & ~ADDR_W'(3);
                remaining <= total_words;
                beat_cnt  <= '0;
            end
            if (do_issue) begin
                cur_len <= 7'(len);
                addr    <= addr + (ADDR_W'(len) << 2);
            end
            if (rd_pop) begin
                if (last_beat) begin
                    beat_cnt  <= '0;
                    remaining <= remaining_after;
                end else begin
                    beat_cnt <= beat_cnt + 7'd1;
                end
            end
        end
    end

`ifdef DMA_RD_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (do_latch) begin
            stall_cnt <= '0;
        end else if (state == XFER && (p_rd_empty || ob_full) && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

    assign p_cmd_en        = do_issue;
    assign p_cmd_instr     = (state == ISSUE) ? 3'b001 : 3'b000;
    assign p_cmd_bl        = (state == ISSUE) ? 6'(len - 16'd1) : 6'd0;
    assign p_cmd_byte_addr = (state == ISSUE) ? addr : '0;
    assign p_rd_en         = rd_pop;
    assign ob_we           = rd_pop;
    assign ob_data         = (state == XFER) ? p_rd_data : 32'd0;
    assign busy            = (state == ISSUE) || (state == XFER);
    assign done            = (state == DONE);

endmodule

// File: tb/tb_dma_rd_ctrl.sv
// Directed bench for dma_rd_ctrl with a queue-based SDRAM read FIFO and output-buffer model.
module tb_dma_rd_ctrl;
    localparam int AW = 30;

    logic          clk = 1'b0;
    logic          rst_n, reads_en, p_cmd_full;
    logic [31:0]   start_addr;
    logic [15:0]   total_words;
    logic          p_cmd_en, p_rd_en, p_rd_empty, ob_we, busy, done;
    logic [2:0]    p_cmd_instr;
    logic [5:0]    p_cmd_bl;
    logic [AW-1:0] p_cmd_byte_addr;
    logic [31:0]   p_rd_data, ob_data;
    logic          ob_full = 1'b0;
`ifdef DMA_RD_STALL_CNT_EN
    logic [31:0]   stall_cnt;
`endif

    always #5 clk = ~clk;

    dma_rd_ctrl #(.BURST_LEN(16), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .reads_en(reads_en),
        .start_addr(start_addr), .total_words(total_words),
        .p_cmd_en(p_cmd_en), .p_cmd_instr(p_cmd_instr), .p_cmd_bl(p_cmd_bl),
        .p_cmd_byte_addr(p_cmd_byte_addr), .p_cmd_full(p_cmd_full),
        .p_rd_en(p_rd_en), .p_rd_data(p_rd_data), .p_rd_empty(p_rd_empty),
        .ob_we(ob_we), .ob_data(ob_data), .ob_full(ob_full),
        .busy(busy), .done(done)
`ifdef DMA_RD_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // SDRAM read FIFO model: each command queues words whose value is their byte address.
    logic [31:0]   rdq[$];
    int            qn = 0;
    logic [31:0]   head = '0;
    bit            force_empty = 1'b0;
    bit            ob_toggle = 1'b0;
    bit            pend_pop = 1'b0;
    bit            pend_cmd = 1'b0;
    logic [AW-1:0] pend_addr = '0;
    int            pend_len = 0;

    logic [31:0]   obq[$];
    logic [AW-1:0] cmd_addr_q[$];
    logic [5:0]    cmd_bl_q[$];
    int            viol = 0;
    int            done_cnt = 0;

    assign p_rd_empty = force_empty | (qn == 0);
    assign p_rd_data  = head;

    always @(negedge clk) begin
        pend_pop = p_rd_en;
        pend_cmd = p_cmd_en;
        if (p_cmd_en) begin
            cmd_addr_q.push_back(p_cmd_byte_addr);
            cmd_bl_q.push_back(p_cmd_bl);
            pend_addr = p_cmd_byte_addr;
            pend_len  = int'(p_cmd_bl) + 1;
            if (p_cmd_instr != 3'b001) viol++;
        end
        if (ob_we) obq.push_back(ob_data);
        if ((ob_we && ob_full) || (ob_we != p_rd_en) || (p_rd_en && p_rd_empty) ||
            (ob_we && ob_data != p_rd_data))
            viol++;
        if (done) done_cnt++;
    end

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            rdq.delete();
        end else begin
            if (pend_pop && rdq.size() > 0) void'(rdq.pop_front());
            if (pend_cmd)
                for (int i = 0; i < pend_len; i++) rdq.push_back(32'(pend_addr) + 32'(4 * i));
            ob_full = ob_toggle ? ~ob_full : 1'b0;
        end
        qn   = rdq.size();
        head = (qn > 0) ? rdq[0] : 32'd0;
    end

    int ob_base = 0;
    int cmd_base = 0;
    int done_base = 0;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic mark();
        ob_base   = obq.size();
        cmd_base  = cmd_addr_q.size();
        done_base = done_cnt;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !done; i++) step(1);
    endtask

    task automatic check_cmd(input string tag, input int i, input logic [AW-1:0] ea, input logic [5:0] eb);
        logic [AW-1:0] a;
        logic [5:0]    b;
        a = (cmd_base + i < cmd_addr_q.size()) ? cmd_addr_q[cmd_base + i] : 'x;
        b = (cmd_base + i < cmd_bl_q.size()) ? cmd_bl_q[cmd_base + i] : 'x;
        check_val({tag, "_addr"}, 64'(a), 64'(ea));
        check_val({tag, "_bl"}, 64'(b), 64'(eb));
    endtask

    task automatic check_data(input string tag, input int n, input logic [AW-1:0] first);
        logic [AW-1:0] a;
        logic [31:0]   got;
        a = first;
        for (int i = 0; i < n; i++) begin
            got = (ob_base + i < obq.size()) ? obq[ob_base + i] : 'x;
            check_val(tag, 64'(got), 64'(32'(a)));
            a = a + AW'(4);
        end
    endtask

    initial begin
        rst_n = 1'b0; reads_en = 1'b0; p_cmd_full = 1'b0;
        start_addr = '0; total_words = '0;
        step(2);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_done", 64'(done), 64'd0);
        check_val("rst_cmd_en", 64'(p_cmd_en), 64'd0);
        check_val("rst_rd_en", 64'(p_rd_en), 64'd0);
        check_val("rst_ob_we", 64'(ob_we), 64'd0);
        check_val("rst_cmd_addr", 64'(p_cmd_byte_addr), 64'd0);
        rst_n = 1'b1;
        step(1);

        // Three bursts, inputs changed after latch must be ignored
        mark();
        start_addr = 32'h000A_0000; total_words = 16'd40; reads_en = 1'b1;
        step(1);
        check_val("a_busy_issue", 64'(busy), 64'd1);
        start_addr = 32'h1234_5678; total_words = 16'd3;
        wait_done(400);
        check_val("a_done", 64'(done), 64'd1);
        check_val("a_busy", 64'(busy), 64'd0);
        check_val("a_ncmd", 64'(cmd_addr_q.size() - cmd_base), 64'd3);
        check_cmd("a_cmd0", 0, 30'h000A_0000, 6'd15);
        check_cmd("a_cmd1", 1, 30'h000A_0040, 6'd15);
        check_cmd("a_cmd2", 2, 30'h000A_0080, 6'd7);
        check_val("a_nwords", 64'(obq.size() - ob_base), 64'd40);
        check_data("a_data", 40, 30'h000A_0000);
        reads_en = 1'b0;
        step(1);
        check_val("a_done_fall", 64'(done), 64'd0);

        // Empty region
        mark();
        start_addr = 32'h0000_0500; total_words = 16'd0; reads_en = 1'b1;
        check_val("b_busy0", 64'(busy), 64'd0);
        step(1);
        check_val("b_done", 64'(done), 64'd1);
        check_val("b_busy1", 64'(busy), 64'd0);
        step(2);
        check_val("b_busy2", 64'(busy), 64'd0);
        check_val("b_ncmd", 64'(cmd_addr_q.size() - cmd_base), 64'd0);
        reads_en = 1'b0;
        step(1);
        check_val("b_done_fall", 64'(done), 64'd0);

        // Command queue full, toggling ob_full, address bits outside [ADDR_W-1:2] dropped
        mark();
        p_cmd_full = 1'b1;
        start_addr = 32'hC000_0103; total_words = 16'd8; reads_en = 1'b1;
        step(1);
        step(5);
        check_val("c_stall_ncmd", 64'(cmd_addr_q.size() - cmd_base), 64'd0);
        check_val("c_stall_en", 64'(p_cmd_en), 64'd0);
        check_val("c_stall_busy", 64'(busy), 64'd1);
        ob_toggle = 1'b1; p_cmd_full = 1'b0;
        #1;
        check_val("c_pulse_en", 64'(p_cmd_en), 64'd1);
        check_val("c_pulse_addr", 64'(p_cmd_byte_addr), 64'h100);
        check_val("c_pulse_bl", 64'(p_cmd_bl), 64'd7);
        wait_done(200);
        check_val("c_done", 64'(done), 64'd1);
        check_val("c_ncmd", 64'(cmd_addr_q.size() - cmd_base), 64'd1);
        check_val("c_nwords", 64'(obq.size() - ob_base), 64'd8);
        check_data("c_data", 8, 30'h100);
        reads_en = 1'b0; ob_toggle = 1'b0;
        step(2);

        // Address wrap at 2^ADDR_W
        mark();
        start_addr = 32'h3FFF_FFC0; total_words = 16'd20; reads_en = 1'b1;
        wait_done(200);
        check_val("d_done", 64'(done), 64'd1);
        check_val("d_ncmd", 64'(cmd_addr_q.size() - cmd_base), 64'd2);
        check_cmd("d_cmd0", 0, 30'h3FFF_FFC0, 6'd15);
        check_cmd("d_cmd1", 1, 30'h0000_0000, 6'd3);
        check_data("d_data", 20, 30'h3FFF_FFC0);
        reads_en = 1'b0;
        step(2);

        // reads_en dropped at beat 3: burst drains, no second command, done never seen
        mark();
        start_addr = 32'h0000_2000; total_words = 16'd32; reads_en = 1'b1;
        for (int i = 0; i < 100 && (obq.size() - ob_base) < 3; i++) step(1);
        reads_en = 1'b0;
        for (int i = 0; i < 100 && busy; i++) step(1);
        step(3);
        check_val("e_busy", 64'(busy), 64'd0);
        check_val("e_ncmd", 64'(cmd_addr_q.size() - cmd_base), 64'd1);
        check_val("e_nwords", 64'(obq.size() - ob_base), 64'd16);
        check_val("e_done_cycles", 64'(done_cnt - done_base), 64'd0);
        check_data("e_data", 16, 30'h2000);

        // Asynchronous reset mid-burst, then a fresh region
        mark();
        start_addr = 32'h0000_5000; total_words = 16'd16; reads_en = 1'b1;
        for (int i = 0; i < 100 && (obq.size() - ob_base) < 5; i++) step(1);
        check_val("f_pre_rd_en", 64'(p_rd_en), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check_val("f_rst_busy", 64'(busy), 64'd0);
        check_val("f_rst_rd_en", 64'(p_rd_en), 64'd0);
        check_val("f_rst_ob_we", 64'(ob_we), 64'd0);
        check_val("f_rst_ob_data", 64'(ob_data), 64'd0);
        check_val("f_rst_done", 64'(done), 64'd0);
        reads_en = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
        mark();
        start_addr = 32'h0000_7000; total_words = 16'd4; reads_en = 1'b1;
        wait_done(100);
        check_val("f_done", 64'(done), 64'd1);
        check_val("f_ncmd", 64'(cmd_addr_q.size() - cmd_base), 64'd1);
        check_cmd("f_cmd0", 0, 30'h7000, 6'd3);
        check_val("f_nwords", 64'(obq.size() - ob_base), 64'd4);
        check_data("f_data", 4, 30'h7000);
        reads_en = 1'b0;
        step(2);

`ifdef DMA_RD_STALL_CNT_EN
        // Seven empty XFER cycles before data is allowed through
        mark();
        force_empty = 1'b1;
        start_addr = 32'h0000_9000; total_words = 16'd4; reads_en = 1'b1;
        for (int i = 0; i < 20 && (cmd_addr_q.size() - cmd_base) < 1; i++) step(1);
        step(7);
        force_empty = 1'b0;
        wait_done(100);
        check_val("g_done", 64'(done), 64'd1);
        check_val("g_stall_cnt", 64'(stall_cnt), 64'd7);
        check_val("g_nwords", 64'(obq.size() - ob_base), 64'd4);
        reads_en = 1'b0;
        step(2);
`endif

        check_val("handshake_viol", 64'(viol), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dma_rd_ctrl.md
DMA_RD_CTRL -- requirements
Module: dma_rd_ctrl

Interface
REQ-001 SHALL have parameter: BURST_LEN, 16, 32-bit words per SDRAM read burst (legal 1..64).
REQ-002 SHALL have parameter: ADDR_W, 30, SDRAM byte-address width.
REQ-003 SHALL have port: clk  in  1  clock.
REQ-004 SHALL have port: rst_n  in  1  asynchronous reset, active-low.
REQ-005 SHALL have port: reads_en  in  1  level request from command sequencer; high = fetch region.
REQ-006 SHALL have port: start_addr  in  32  region byte address; bits [1:0] ignored, treated as 0.
REQ-007 SHALL have port: total_words  in  16  region length in 32-bit words.
REQ-008 SHALL have port: p_cmd_en  out  1  one-cycle SDRAM command strobe.
REQ-009 SHALL have port: p_cmd_instr  out  3  command opcode; 3'b001 = read.
REQ-010 SHALL have port: p_cmd_bl  out  6  burst length minus one.
REQ-011 SHALL have port: p_cmd_byte_addr  out  ADDR_W  burst byte address.
REQ-012 SHALL have port: p_cmd_full  in  1  SDRAM command queue full.
REQ-013 SHALL have port: p_rd_en / p_rd_data / p_rd_empty  out 1 / in 32 / in 1  SDRAM read-data FIFO pop, data, empty.
REQ-014 SHALL have port: ob_we / ob_data / ob_full  out 1 / out 32 / in 1  output-buffer write, data, full.
REQ-015 SHALL have port: busy / done  out 1 / out 1  transfer in progress / region complete.

Function
REQ-016 SHALL implement states IDLE, ISSUE, XFER, DONE.
REQ-017 IDLE: SHALL, when reads_en=1, latch start_addr[ADDR_W-1:2] (word aligned) and total_words into remaining; SHALL go to DONE if total_words=0, else ISSUE.
REQ-018 ISSUE: SHALL, when p_cmd_full=0, pulse p_cmd_en for exactly 1 cycle with p_cmd_instr=3'b001, len=min(remaining,BURST_LEN), p_cmd_bl=len-1, p_cmd_byte_addr=current address, then go to XFER; SHALL stall with p_cmd_en=0 while p_cmd_full=1.
REQ-019 Address SHALL advance by 4*len bytes per issued burst and wrap modulo 2^ADDR_W.
REQ-020 XFER: p_rd_en SHALL be combinational = !p_rd_empty & !ob_full; ob_we SHALL equal p_rd_en and ob_data SHALL equal p_rd_data in the same cycle (zero latency).
REQ-021 XFER: SHALL count beats; on the len-th beat remaining -= len; SHALL go to ISSUE if remaining>0 and reads_en=1, to IDLE if reads_en=0, else to DONE.
REQ-022 p_rd_en SHALL be 0 in every state other than XFER, and no beats beyond len SHALL be popped per burst.
REQ-023 DONE: done SHALL be 1; SHALL return to IDLE when reads_en=0 (done falls the cycle after).
REQ-024 reads_en deasserted in ISSUE SHALL return to IDLE without issuing; deasserted in XFER SHALL drain the current burst fully, then go to IDLE with done never asserted.
REQ-025 busy SHALL be 1 in ISSUE and XFER, 0 in IDLE and DONE.
REQ-026 start_addr/total_words changes after latch SHALL be ignored until the next IDLE exit.

Reset
REQ-027 Reset SHALL force IDLE, all outputs 0, remaining/address/beat counters 0, at any time including mid-burst; SDRAM-side FIFO contents are not flushed by this block.

Configuration
REQ-028 With DMA_RD_STALL_CNT_EN defined, SHALL add output stall_cnt (32) counting XFER cycles with p_rd_empty=1 or ob_full=1, cleared on IDLE->ISSUE/DONE, saturating at 2^32-1; without it, port and counter SHALL not exist.

Verification
REQ-029 start_addr=0x000A_0000, total_words=40, BURST_LEN=16, no backpressure -> 3 commands: addr 0xA0000 bl 15, 0xA0040 bl 15, 0xA0080 bl 7; 40 ob_we; done=1.
REQ-030 total_words=0, reads_en=1 -> no p_cmd_en, done=1 next cycle, busy=0 throughout.
REQ-031 p_cmd_full=1 for 5 cycles in ISSUE -> p_cmd_en held 0, then single pulse; ob_full toggled every cycle -> ob_we never coincides with ob_full=1, data order preserved.
REQ-032 reads_en dropped at beat 3 of burst 1 (total_words=32) -> remaining 13 beats of that burst popped, no second command, done stays 0, return to IDLE.
REQ-033 rst_n asserted mid-XFER -> all outputs 0 immediately; subsequent reads_en starts fresh from new start_addr.
REQ-034 DMA_RD_STALL_CNT_EN defined, p_rd_empty=1 for 7 XFER cycles -> stall_cnt=7 at done.
